// File: rtl/rtc_timekeeper_if.sv
// Time-set handshake and alarm-programming bus for rtc_timekeeper.
interface rtc_timekeeper_if;
    localparam int unsigned HW = 5;
    localparam int unsigned MW = 6;

    logic          set_valid;
    logic          set_ready;
    logic [HW-1:0] set_hours;
    logic [MW-1:0] set_minutes;
    logic [MW-1:0] set_seconds;
    logic          set_err;
    logic          alarm_we;
    logic          alarm_arm;
    logic [HW-1:0] alarm_hours;
    logic [MW-1:0] alarm_minutes;

    modport master (
        output set_valid, set_hours, set_minutes, set_seconds,
        output alarm_we, alarm_arm, alarm_hours, alarm_minutes,
        input  set_ready, set_err
    );

    modport slave (
        input  set_valid, set_hours, set_minutes, set_seconds,
        input  alarm_we, alarm_arm, alarm_hours, alarm_minutes,
        output set_ready, set_err
    );
endinterface

// File: rtl/rtc_timekeeper.sv
// Real-time clock: prescaled seconds counter with time-set handshake and 12/24h display.
// Define RTC_TIMEKEEPER_ALARM_EN to build the programmable alarm.
module rtc_timekeeper #(
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned HOUR_MODE = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  init_hours,
    input  logic [5:0]  init_minutes,
    input  logic [5:0]  init_seconds,
    input  logic        run,
    rtc_timekeeper_if.slave bus,
    output logic [16:0] watch,
    output logic        pm,
    output logic        sec_tick,
    output logic        rollover,
    output logic        alarm_hit
);
    localparam int unsigned HW = 5;
    localparam int unsigned MW = 6;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state;
    logic [PW-1:0] ps;
    logic [HW-1:0] hours;
    logic [MW-1:0] minutes;
    logic [MW-1:0] seconds;
    logic [HW-1:0] disp_h;
    logic          set_ready_q;
    logic          set_err_q;

    logic          tick_c, accept_c, set_ok_c, wrap_c, upd_c;
    logic [HW-1:0] ini_h_c, inc_h_c, nxt_h_c;
    logic [MW-1:0] ini_m_c, ini_s_c, inc_m_c, inc_s_c, nxt_m_c, nxt_s_c;

    function automatic logic [HW-1:0] disp_hours(input logic [HW-1:0] h);
        if (HOUR_MODE == 12) begin
            if (h == 5'd0 || h == 5'd12) return 5'd12;
            if (h > 5'd12)               return h - 5'd12;
        end
        return h;
    endfunction

    function automatic logic is_pm(input logic [HW-1:0] h);
        return (HOUR_MODE == 12) && (h >= 5'd12);
    endfunction

    assign tick_c   = run && (ps == PS_LAST);
    assign accept_c = bus.set_valid && (state == IDLE);
    assign set_ok_c = (bus.set_hours < 5'd24) && (bus.set_minutes < 6'd60) &&
                      (bus.set_seconds < 6'd60);
    assign wrap_c   = (hours == 5'd23) && (minutes == 6'd59) && (seconds == 6'd59);

    // Out-of-range init fields fall back to zero individually.
    assign ini_h_c = (init_hours   < 5'd24) ? init_hours   : '0;
    assign ini_m_c = (init_minutes < 6'd60) ? init_minutes : '0;
    assign ini_s_c = (init_seconds < 6'd60) ? init_seconds : '0;

    // One-second increment with cascaded carries.
    always_comb begin
        inc_h_c = hours;
        inc_m_c = minutes;
        inc_s_c = seconds + 6'd1;
        if (seconds == 6'd59) begin
            inc_s_c = '0;
            inc_m_c = minutes + 6'd1;
            if (minutes == 6'd59) begin
                inc_m_c = '0;
                inc_h_c = (hours == 5'd23) ? '0 : hours + 5'd1;
            end
        end
    end

    // A set accepted in the same cycle as a tick takes priority and drops the tick.
    always_comb begin
        upd_c   = 1'b0;
        nxt_h_c = hours;
        nxt_m_c = minutes;
        nxt_s_c = seconds;
        if (accept_c) begin
            if (set_ok_c) begin
                upd_c   = 1'b1;
                nxt_h_c = bus.set_hours;
                nxt_m_c = bus.set_minutes;
                nxt_s_c = bus.set_seconds;
            end
        end else if (tick_c) begin
            upd_c   = 1'b1;
            nxt_h_c = inc_h_c;
            nxt_m_c = inc_m_c;
            nxt_s_c = inc_s_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            set_ready_q <= 1'b1;
            set_err_q   <= 1'b0;
            ps          <= '0;
            hours       <= ini_h_c;
            minutes     <= ini_m_c;
            seconds     <= ini_s_c;
            disp_h      <= disp_hours(ini_h_c);
            pm          <= is_pm(ini_h_c);
            sec_tick    <= 1'b0;
            rollover    <= 1'b0;
        end else begin
            set_err_q <= 1'b0;
            sec_tick  <= 1'b0;
            rollover  <= 1'b0;

            if (run) ps <= tick_c ? '0 : ps + PW'(1);

            case (state)
                IDLE: if (accept_c) begin
                    state       <= HOLD;
                    set_ready_q <= 1'b0;
                    set_err_q   <= !set_ok_c;
                    if (set_ok_c) ps <= '0;
                end
                HOLD: begin
                    state       <= IDLE;
                    set_ready_q <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    set_ready_q <= 1'b1;
                end
            endcase

            if (upd_c) begin
                hours   <= nxt_h_c;
                minutes <= nxt_m_c;
                seconds <= nxt_s_c;
                disp_h  <= disp_hours(nxt_h_c);
                pm      <= is_pm(nxt_h_c);
            end

            if (tick_c && !accept_c) begin
                sec_tick <= 1'b1;
                rollover <= wrap_c;
            end
        end
    end

    assign watch         = {disp_h, minutes, seconds};
    assign bus.set_ready = set_ready_q;
    assign bus.set_err   = set_err_q;

`ifdef RTC_TIMEKEEPER_ALARM_EN
    logic [HW-1:0] alarm_h;
    logic [MW-1:0] alarm_m;
    logic          armed;

    // Alarm fires only on a tick that lands on hh:mm:00, never on a set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_h   <= '0;
            alarm_m   <= '0;
            armed     <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            alarm_hit <= armed && tick_c && !accept_c && (inc_h_c == alarm_h) &&
                         (inc_m_c == alarm_m) && (inc_s_c == 6'd0);
            if (bus.alarm_we && (bus.alarm_hours < 5'd24) && (bus.alarm_minutes < 6'd60)) begin
                alarm_h <= bus.alarm_hours;
                alarm_m <= bus.alarm_minutes;
                armed   <= bus.alarm_arm;
            end
        end
    end
`else
    logic unused_alarm;
    assign unused_alarm = ^{bus.alarm_we, bus.alarm_arm, bus.alarm_hours, bus.alarm_minutes};
    assign alarm_hit    = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed scoreboard bench for rtc_timekeeper: 24h/TICK_DIV=4 and 12h/TICK_DIV=1 instances.
module tb_rtc_timekeeper;
`ifdef RTC_TIMEKEEPER_ALARM_EN
    localparam logic AEN = 1'b1;
`else
    localparam logic AEN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [16:0] watch;
        logic        pm, tick, roll, hit, ready, err;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // Instance A: TICK_DIV=4, 24h display
    logic        rst_a, run_a;
    logic [4:0]  ih_a;
    logic [5:0]  im_a, is_a;
    logic [16:0] watch_a;
    logic        pm_a, tick_a, roll_a, hit_a;
    rtc_timekeeper_if bus_a ();

    rtc_timekeeper #(.TICK_DIV(4), .HOUR_MODE(24)) u_a (
        .clk(clk), .rst(rst_a), .init_hours(ih_a), .init_minutes(im_a), .init_seconds(is_a),
        .run(run_a), .bus(bus_a.slave), .watch(watch_a), .pm(pm_a), .sec_tick(tick_a),
        .rollover(roll_a), .alarm_hit(hit_a)
    );

    // Instance B: TICK_DIV=1, 12h display
    logic        rst_b, run_b;
    logic [4:0]  ih_b;
    logic [5:0]  im_b, is_b;
    logic [16:0] watch_b;
    logic        pm_b, tick_b, roll_b, hit_b;
    rtc_timekeeper_if bus_b ();

    rtc_timekeeper #(.TICK_DIV(1), .HOUR_MODE(12)) u_b (
        .clk(clk), .rst(rst_b), .init_hours(ih_b), .init_minutes(im_b), .init_seconds(is_b),
        .run(run_b), .bus(bus_b.slave), .watch(watch_b), .pm(pm_b), .sec_tick(tick_b),
        .rollover(roll_b), .alarm_hit(hit_b)
    );

    function automatic logic [16:0] tw(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic push_exp(input string tag, input logic [16:0] w, input logic p,
                            input logic t, input logic r, input logic h,
                            input logic rdy, input logic e);
        exp_t x;
        x.tag = tag; x.watch = w; x.pm = p; x.tick = t; x.roll = r;
        x.hit = h; x.ready = rdy; x.err = e;
        sbq.push_back(x);
    endtask

    task automatic chkw(input string tag, input string f, input logic [16:0] obs,
                        input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input string f, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, f, obs, exp);
        end
    endtask

    task automatic compare_next(input bit sel_b);
        exp_t x;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1 entries");
            return;
        end
        x = sbq.pop_front();
        if (!sel_b) begin
            chkw(x.tag, "watch", watch_a, x.watch);
            chkb(x.tag, "pm", pm_a, x.pm);
            chkb(x.tag, "sec_tick", tick_a, x.tick);
            chkb(x.tag, "rollover", roll_a, x.roll);
            chkb(x.tag, "alarm_hit", hit_a, x.hit);
            chkb(x.tag, "set_ready", bus_a.set_ready, x.ready);
            chkb(x.tag, "set_err", bus_a.set_err, x.err);
        end else begin
            chkw(x.tag, "watch", watch_b, x.watch);
            chkb(x.tag, "pm", pm_b, x.pm);
            chkb(x.tag, "sec_tick", tick_b, x.tick);
            chkb(x.tag, "rollover", roll_b, x.roll);
            chkb(x.tag, "alarm_hit", hit_b, x.hit);
            chkb(x.tag, "set_ready", bus_b.set_ready, x.ready);
            chkb(x.tag, "set_err", bus_b.set_err, x.err);
        end
    endtask

    // One clock edge, then sample on the falling edge.
    task automatic cyc(input bit sel_b);
        @(posedge clk);
        @(negedge clk);
        compare_next(sel_b);
    endtask

    task automatic step_a(input string tag, input int h, input int m, input int s,
                          input logic t, input logic r, input logic rdy, input logic e);
        push_exp(tag, tw(h, m, s), 1'b0, t, r, 1'b0, rdy, e);
        cyc(1'b0);
    endtask

    task automatic step_b(input string tag, input int dh, input int m, input int s,
                          input logic p, input logic t, input logic r, input logic h,
                          input logic rdy);
        push_exp(tag, tw(dh, m, s), p, t, r, h, rdy, 1'b0);
        cyc(1'b1);
    endtask

    task automatic set_a(input logic v, input int h, input int m, input int s);
        bus_a.set_valid = v; bus_a.set_hours = 5'(h);
        bus_a.set_minutes = 6'(m); bus_a.set_seconds = 6'(s);
    endtask

    task automatic set_b(input logic v, input int h, input int m, input int s);
        bus_b.set_valid = v; bus_b.set_hours = 5'(h);
        bus_b.set_minutes = 6'(m); bus_b.set_seconds = 6'(s);
    endtask

    task automatic alarm_b(input logic we, input logic arm, input int h, input int m);
        bus_b.alarm_we = we; bus_b.alarm_arm = arm;
        bus_b.alarm_hours = 5'(h); bus_b.alarm_minutes = 6'(m);
    endtask

    initial begin
        rst_a = 1'b1; run_a = 1'b1; ih_a = 5'd23; im_a = 6'd59; is_a = 6'd58;
        set_a(1'b0, 0, 0, 0);
        bus_a.alarm_we = 1'b0; bus_a.alarm_arm = 1'b0;
        bus_a.alarm_hours = '0; bus_a.alarm_minutes = '0;
        rst_b = 1'b1; run_b = 1'b1; ih_b = 5'd11; im_b = 6'd59; is_b = 6'd59;
        set_b(1'b0, 0, 0, 0);
        alarm_b(1'b0, 1'b0, 0, 0);

        // ---- Instance A: reset, prescaled count and rollover
        @(negedge clk); @(negedge clk);
        push_exp("a_reset", tw(23, 59, 58), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        compare_next(1'b0);
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) step_a("a_pre", 23, 59, 58, 1'b0, 1'b0, 1'b1, 1'b0);
        step_a("a_tick4", 23, 59, 59, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step_a("a_wait", 23, 59, 59, 1'b0, 1'b0, 1'b1, 1'b0);
        step_a("a_rollover", 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step_a("a_post", 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        // ---- Instance A: set on a tick cycle wins, prescaler restarts
        set_a(1'b1, 7, 30, 15);
        step_a("a_set_on_tick", 7, 30, 15, 1'b0, 1'b0, 1'b0, 1'b0);
        set_a(1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step_a("a_after_set", 7, 30, 15, 1'b0, 1'b0, 1'b1, 1'b0);
        step_a("a_tick_after_set", 7, 30, 16, 1'b1, 1'b0, 1'b1, 1'b0);

        // ---- Instance A: out-of-range set is rejected with set_err
        set_a(1'b1, 24, 0, 0);
        step_a("a_bad_set", 7, 30, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        set_a(1'b0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step_a("a_bad_after", 7, 30, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        step_a("a_tick_bad", 7, 30, 17, 1'b1, 1'b0, 1'b1, 1'b0);

        // ---- Instance A: run=0 freezes prescaler
        run_a = 1'b0;
        for (int i = 0; i < 3; i++) step_a("a_frozen", 7, 30, 17, 1'b0, 1'b0, 1'b1, 1'b0);
        run_a = 1'b1;
        for (int i = 0; i < 3; i++) step_a("a_resume", 7, 30, 17, 1'b0, 1'b0, 1'b1, 1'b0);
        step_a("a_tick_resume", 7, 30, 18, 1'b1, 1'b0, 1'b1, 1'b0);

        // ---- Instance A: reset with prescaler at 2 and FSM in HOLD
        step_a("a_ps1", 7, 30, 18, 1'b0, 1'b0, 1'b1, 1'b0);
        set_a(1'b1, 0, 60, 0);
        step_a("a_hold", 7, 30, 18, 1'b0, 1'b0, 1'b0, 1'b1);
        set_a(1'b0, 0, 0, 0);
        rst_a = 1'b1;
        #1;
        push_exp("a_mid_reset", tw(23, 59, 58), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        compare_next(1'b0);
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) step_a("a_rel", 23, 59, 58, 1'b0, 1'b0, 1'b1, 1'b0);
        step_a("a_rel_tick", 23, 59, 59, 1'b1, 1'b0, 1'b1, 1'b0);

        // ---- Instance B: 12h display
        push_exp("b_reset", tw(11, 59, 59), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        compare_next(1'b1);
        rst_b = 1'b0;
        step_b("b_noon", 12, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step_b("b_noon1", 12, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        ih_b = 5'd0; im_b = 6'd0; is_b = 6'd0;
        rst_b = 1'b1; run_b = 1'b0;
        #1;
        push_exp("b_midnight_reset", tw(12, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        compare_next(1'b1);
        @(negedge clk);
        rst_b = 1'b0;
        step_b("b_frozen", 12, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_b(1'b1, 12, 59, 59);
        step_b("b_set_1259", 12, 59, 59, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_b(1'b0, 0, 0, 0);
        step_b("b_hold_done", 12, 59, 59, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_b = 1'b1;
        step_b("b_1pm", 1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_b = 1'b0;
        set_b(1'b1, 23, 59, 59);
        step_b("b_set_2359", 11, 59, 59, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_b(1'b0, 0, 0, 0);
        run_b = 1'b1;
        step_b("b_wrap_in_hold", 12, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        run_b = 1'b0;

        // ---- Instance B: alarm armed at 06:00
        alarm_b(1'b1, 1'b1, 6, 0);
        step_b("b_arm_0600", 12, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        alarm_b(1'b0, 1'b0, 0, 0);
        set_b(1'b1, 5, 59, 58);
        step_b("b_set_055958", 5, 59, 58, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_b(1'b0, 0, 0, 0);
        run_b = 1'b1;
        step_b("b_alarm_pre", 5, 59, 59, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step_b("b_alarm_hit", 6, 0, 0, 1'b0, 1'b1, 1'b0, AEN, 1'b1);
        step_b("b_alarm_post", 6, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_b = 1'b0;

        // ---- Instance B: disarmed write gives no hit
        alarm_b(1'b1, 1'b0, 6, 1);
        step_b("b_disarm", 6, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        alarm_b(1'b0, 1'b0, 0, 0);
        set_b(1'b1, 6, 0, 59);
        step_b("b_set_060059", 6, 0, 59, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_b(1'b0, 0, 0, 0);
        run_b = 1'b1;
        step_b("b_disarmed_reach", 6, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_b = 1'b0;

        // ---- Instance B: set onto alarm time does not fire
        alarm_b(1'b1, 1'b1, 7, 0);
        step_b("b_arm_0700", 6, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        alarm_b(1'b0, 1'b0, 0, 0);
        set_b(1'b1, 7, 0, 0);
        step_b("b_set_on_alarm", 7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_b(1'b0, 0, 0, 0);
        step_b("b_set_on_alarm2", 7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // ---- Instance B: midnight alarm with rollover; bad alarm write discarded
        alarm_b(1'b1, 1'b1, 0, 0);
        step_b("b_arm_0000", 7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        alarm_b(1'b1, 1'b1, 24, 0);
        step_b("b_bad_alarm", 7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        alarm_b(1'b0, 1'b0, 0, 0);
        set_b(1'b1, 23, 59, 59);
        step_b("b_set_2359b", 11, 59, 59, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_b(1'b0, 0, 0, 0);
        run_b = 1'b1;
        step_b("b_alarm_rollover", 12, 0, 0, 1'b0, 1'b1, 1'b1, AEN, 1'b1);
        run_b = 1'b0;

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtc_timekeeper.md
RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1: clk cycles per one-second advance, legal range >=1.
REQ-002 SHALL have parameter HOUR_MODE, default 24: display mode, legal values 24 or 12.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports init_hours/init_minutes/init_seconds  in  5/6/6  time loaded at reset, 24h coding.
REQ-006 SHALL have port run  in  1  count enable; 0 freezes prescaler and time.
REQ-007 SHALL have ports set_valid in 1, set_ready out 1, set_hours/set_minutes/set_seconds in 5/6/6  time-set handshake, 24h coding.
REQ-008 SHALL have port set_err  out  1  one-cycle pulse: accepted set had an out-of-range field.
REQ-009 SHALL have ports alarm_we in 1, alarm_arm in 1, alarm_hours/alarm_minutes in 5/6  alarm programming.
REQ-010 SHALL have port watch  out  17  {hours, minutes, seconds} in display coding.
REQ-011 SHALL have ports pm out 1, sec_tick out 1, rollover out 1, alarm_hit out 1.

Function
REQ-012 Internal time SHALL be hours 0-23, minutes 0-59, seconds 0-59, always 24h coded.
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 while run=1; tick when count==TICK_DIV-1 and run=1; count then returns to 0.
REQ-014 On tick, seconds SHALL increment; 59 wraps to 0 and carries to minutes; minutes 59 wraps and carries to hours; hours 23 wraps to 0.
REQ-015 With TICK_DIV=1 and run=1, time SHALL advance every clk cycle.
REQ-016 sec_tick SHALL pulse high for exactly the cycle in which the advanced time is first visible on watch.
REQ-017 rollover SHALL pulse with sec_tick on the 23:59:59 -> 00:00:00 transition only.
REQ-018 HOUR_MODE=24: watch hours = internal hours; pm = 0.
REQ-019 HOUR_MODE=12: watch hours = 12 for internal 0 and 12, internal mod 12 otherwise; pm = 1 when internal hours >= 12.
REQ-020 Set FSM SHALL have states IDLE (set_ready=1) and HOLD (set_ready=0); accept = set_valid && set_ready in IDLE.
REQ-021 On accept, FSM SHALL go to HOLD for exactly one cycle, then return to IDLE.
REQ-022 On accept with all set fields in range, time SHALL load set values at that edge and prescaler SHALL clear to 0; no sec_tick for that edge.
REQ-023 On accept with any field out of range, time SHALL be unchanged and set_err SHALL pulse the following cycle.
REQ-024 Accept and tick in the same cycle: set SHALL win; the tick is discarded.
REQ-025 alarm_we SHALL write alarm_hours/minutes and armed flag = alarm_arm; an out-of-range field SHALL discard the whole write.
REQ-026 alarm_hit SHALL pulse one cycle, coincident with sec_tick, when armed and a tick produces hours==alarm_hours, minutes==alarm_minutes, seconds==0.
REQ-027 A set landing on the alarm time SHALL NOT raise alarm_hit.
REQ-028 Time reaching the alarm time at rollover SHALL raise alarm_hit and rollover together.

Reset
REQ-029 During rst: time = init values (any out-of-range field loads 0), prescaler = 0, FSM = IDLE, alarm = 00:00 disarmed.
REQ-030 During rst: set_ready = 1; set_err, sec_tick, rollover and alarm_hit = 0; pm and watch reflect the init time.
REQ-031 rst asserted mid-handshake or mid-prescale SHALL abandon the operation without a pulse output.

Configuration
REQ-032 Macro RTC_TIMEKEEPER_ALARM_EN defined: alarm logic per REQ-025..028 is present.
REQ-033 Macro RTC_TIMEKEEPER_ALARM_EN undefined: alarm ports remain, inputs are ignored, alarm_hit is tied 0, and no alarm registers exist.

Verification
REQ-034 TICK_DIV=4, init 23:59:58, run=1 -> 00:00:00 after 8 clk; rollover pulse with that update; sec_tick every 4th cycle.
REQ-035 HOUR_MODE=12, init 11:59:59, TICK_DIV=1 -> watch hours 12, pm=1 next cycle; init 00:00:00 -> watch hours 12, pm=0.
REQ-036 Accept set 07:30:15 on a tick cycle -> watch 07:30:15, no sec_tick; set_ready low 1 cycle; set 24:00:00 -> time unchanged, set_err pulse.
REQ-037 ALARM_EN, alarm 06:00 armed, init 05:59:58, TICK_DIV=1 -> alarm_hit on second tick only; disarmed write -> no hit.
REQ-038 rst asserted with prescaler at 2 of 4 and FSM in HOLD -> prescaler 0, IDLE, init time, no pulses after release.
